pn_token_encoder: RTL

Front-end stage that sits directly upstream of the PN evaluator. It receives an expression as a byte stream of ASCII characters, one frame per expression, and buffers up to 12 tokens. It checks the frame for structural validity against the frame's mode. A valid frame is replayed as one contiguous mode/operator/in/in_valid burst to PN; the block then waits for PN's results before accepting the next frame.

---
 rtl/pn_pkg.sv | 25 ++
 rtl/pn_char_decode.sv | 28 ++
 rtl/pn_token_encoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pn_pkg.sv
// pn_pkg: shared constants and types for the PN token encoder and its decoder
package pn_pkg;
  localparam int         MAX_TOK   = 12;
  localparam logic [7:0] TERM_CHAR = 8'h3B;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_SEVEN  = 8'h37;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_BAR    = 8'h7C;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_ABS = 3'd3;
  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;
  typedef struct packed {
    logic       op;
    logic [2:0] val;
  } tok_t;
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_DROP, S_CHECK, S_SEND, S_WAIT} state_t;
endpackage

// File: rtl/pn_char_decode.sv
// pn_char_decode: classifies one ASCII character into token/terminator/space/illegal
module pn_char_decode
  import pn_pkg::*;
(
  input  logic [7:0] ch_data,
  output logic       is_tok,
  output logic       is_term,
  output logic       is_space,
  output logic       is_illegal,
  output logic       op,
  output logic [2:0] val
);
  logic is_dig, is_opr;
  // digits carry their value in the low bits; operators map to their op code
  always_comb begin
    is_dig     = ch_data >= CH_ZERO && ch_data <= CH_SEVEN;
    is_opr     = ch_data == CH_PLUS || ch_data == CH_MINUS || ch_data == CH_STAR || ch_data == CH_BAR;
    is_space   = ch_data == CH_SPACE;
    is_term    = ch_data == TERM_CHAR;
    is_tok     = is_dig || is_opr;
    is_illegal = !(is_tok || is_space || is_term);
    op         = is_opr;
    val        = is_dig ? ch_data[2:0] :
                 ch_data == CH_MINUS ? OP_SUB :
                 ch_data == CH_STAR  ? OP_MUL :
                 ch_data == CH_BAR   ? OP_ABS : OP_ADD;
  end
endmodule

// File: rtl/pn_token_encoder.sv
// pn_token_encoder: buffers a character frame, validates it and replays it as a PN burst
module pn_token_encoder
  import pn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  input  logic [1:0] frame_mode,
  output logic       ch_ready,
  output logic [1:0] mode,
  output logic       operator,
  output logic [2:0] in,
  output logic       in_valid,
  input  logic       pn_out_valid,
  output logic       frame_done,
  output logic       err
);
  state_t     state_q, state_d;
  tok_t       tok_buf_q [MAX_TOK];
  tok_t       tok_buf_d [MAX_TOK];
  tok_t       tok;
  logic [3:0] tok_cnt_q, tok_cnt_d, opr_cnt_q, opr_cnt_d, rd_ptr_q, rd_ptr_d;
  logic [3:0] res_cnt_q, res_cnt_d, exp_q, exp_d;
  logic [1:0] mode_reg_q, mode_reg_d;
  logic [2:0] in_q, in_d;
  logic       ch_ready_q, ch_ready_d, operator_q, operator_d, in_valid_q, in_valid_d;
  logic       frame_done_q, frame_done_d, err_q, err_d;
  logic       is_tok, is_term, is_space, is_illegal, dec_op, acc, pass;
  logic [2:0] dec_val;

  pn_char_decode u_dec (
    .ch_data    (ch_data),
    .is_tok     (is_tok),
    .is_term    (is_term),
    .is_space   (is_space),
    .is_illegal (is_illegal),
    .op         (dec_op),
    .val        (dec_val)
  );

  assign tok  = {dec_op, dec_val};
  assign acc  = ch_valid && ch_ready_q;
  // modes 0/1 need whole groups of three; modes 2/3 need operands = operators + 1
  assign pass = (mode_reg_q >= MODE_2) ? ({opr_cnt_q, 1'b1} == {1'b0, tok_cnt_q})
                                       : (tok_cnt_q inside {4'd3, 4'd6, 4'd9, 4'd12});

  // next-state, buffer writes and registered output values
  always_comb begin
    state_d      = state_q;
    tok_buf_d    = tok_buf_q;
    tok_cnt_d    = tok_cnt_q;
    opr_cnt_d    = opr_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    res_cnt_d    = res_cnt_q;
    exp_d        = exp_q;
    mode_reg_d   = mode_reg_q;
    operator_d   = 1'b0;
    in_d         = 3'd0;
    in_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: if (acc) begin
        if (is_tok) begin
          mode_reg_d   = frame_mode;
          tok_buf_d[0] = tok;
          tok_cnt_d    = 4'd1;
          opr_cnt_d    = {3'd0, dec_op};
          state_d      = S_COLLECT;
        end else if (is_term) err_d = 1'b1;
        else if (!is_space) state_d = S_DROP;
      end
      S_COLLECT: if (acc) begin
        if (is_tok && tok_cnt_q != 4'(MAX_TOK)) begin
          tok_buf_d[tok_cnt_q] = tok;
          tok_cnt_d            = tok_cnt_q + 4'd1;
          opr_cnt_d            = opr_cnt_q + {3'd0, dec_op};
        end else if (is_tok || is_illegal) state_d = S_DROP;
        else if (is_term) state_d = S_CHECK;
      end
      S_DROP: if (acc && is_term) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_CHECK: if (pass) begin
        {operator_d, in_d} = tok_buf_q[0];
        in_valid_d         = 1'b1;
        rd_ptr_d           = 4'd1;
        res_cnt_d          = 4'd0;
        exp_d              = (mode_reg_q >= MODE_2) ? 4'd1 : tok_cnt_q / 4'd3;
        state_d            = S_SEND;
      end else begin
        err_d     = 1'b1;
        tok_cnt_d = 4'd0;
        state_d   = S_IDLE;
      end
      S_SEND: if (rd_ptr_q < tok_cnt_q) begin
        {operator_d, in_d} = tok_buf_q[rd_ptr_q];
        in_valid_d         = 1'b1;
        rd_ptr_d           = rd_ptr_q + 4'd1;
      end else state_d = S_WAIT;
      S_WAIT: if (pn_out_valid) begin
        res_cnt_d = res_cnt_q + 4'd1;
        if (res_cnt_q + 4'd1 == exp_q) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ch_ready_d = (state_d inside {S_IDLE, S_COLLECT, S_DROP}) && !frame_done_d;
  end

  // state and output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tok_buf_q    <= '{default: '0};
      tok_cnt_q    <= '0;
      opr_cnt_q    <= '0;
      rd_ptr_q     <= '0;
      res_cnt_q    <= '0;
      exp_q        <= '0;
      mode_reg_q   <= '0;
      ch_ready_q   <= 1'b0;
      operator_q   <= 1'b0;
      in_q         <= '0;
      in_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tok_buf_q    <= tok_buf_d;
      tok_cnt_q    <= tok_cnt_d;
      opr_cnt_q    <= opr_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      res_cnt_q    <= res_cnt_d;
      exp_q        <= exp_d;
      mode_reg_q   <= mode_reg_d;
      ch_ready_q   <= ch_ready_d;
      operator_q   <= operator_d;
      in_q         <= in_d;
      in_valid_q   <= in_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign ch_ready   = ch_ready_q;
  assign mode       = mode_reg_q;
  assign operator   = operator_q;
  assign in         = in_q;
  assign in_valid   = in_valid_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
endmodule
